// File: rtl/matmul_sched_pkg.sv
// Shared definitions for the matmul_sched sequencer.
//   state_e   : controller FSM states
//   drain_lat : cycles to wait after the last read before the tree result is stable
package matmul_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StWrite,
        StDone
    } state_e;

    // Read latency, one cycle per adder-tree level, plus the lane-multiply and
    // accumulate stages.
    function automatic int unsigned drain_lat(input int unsigned accu_num_log2,
                                              input int unsigned rd_lat);
        return rd_lat + accu_num_log2 + 2;
    endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth shift register used to align per-cycle read-side control with the
// SRAM read data.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears every stage
//   i_data : value entering the line
//   o_data : i_data delayed by DEPTH cycles (pass-through when DEPTH is 0)
module sched_delay_line #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int s = 0; s < int'(DEPTH); s++) begin
                        r_stage[s] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int s = 1; s < int'(DEPTH); s++) begin
                        r_stage[s] <= r_stage[s-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/matmul_sched.sv
// Sequencing controller for the MultAddTree dot-product datapath.
// Walks the OA_H x OA_W output matrix, column m outermost and row tile j inner,
// issuing activation/weight reads for each reduction step, letting the tree drain,
// then writing one row tile of results.
//
// Optional feature macro: PERF_CNT_EN adds the perf_cycles output (busy cycle count
// of the last job, cleared at start).
//
// Ports:
//   clk, reset_n          : clock, synchronous active-high reset
//   start, cfg_*          : job launch pulse and job dimensions / result shift
//   act_rd_*, wet_rd_*    : activation and weight SRAM read requests
//   lane_mask             : per-lane valid, aligned with SRAM read data
//   PE_*                  : MultAddTree control and result
//   out_wr_*              : output SRAM write (registered, one cycle after WRITE)
//   busy, done            : job in progress / one-cycle end-of-job pulse
//   perf_cycles           : busy cycle count (PERF_CNT_EN only)
module matmul_sched
    import matmul_sched_pkg::*;
#(
    parameter int unsigned MAC_NUM       = 1,
    parameter int unsigned ACCU_NUM_LOG2 = 1,
    parameter int unsigned BW_ACT        = 8,
    parameter int unsigned DIM_W         = 12,
    parameter int unsigned RD_LAT        = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [DIM_W-1:0]              cfg_ia_h,
    input  logic [DIM_W-1:0]              cfg_ia_w,
    input  logic [DIM_W-1:0]              cfg_oa_w,
    input  logic [7:0]                    cfg_shift,
    output logic                          act_rd_en,
    output logic [DIM_W-1:0]              act_rd_row,
    output logic [DIM_W-1:0]              act_rd_col,
    output logic                          wet_rd_en,
    output logic [DIM_W-1:0]              wet_rd_row,
    output logic [DIM_W-1:0]              wet_rd_col,
    output logic [(1<<ACCU_NUM_LOG2)-1:0] lane_mask,
    output logic                          PE_mac_enable,
    output logic                          PE_clear_acc,
    output logic [7:0]                    PE_res_shift_num,
    input  logic [MAC_NUM*BW_ACT-1:0]     PE_result_out,
    output logic                          out_wr_en,
    output logic [DIM_W-1:0]              out_wr_row,
    output logic [DIM_W-1:0]              out_wr_col,
    output logic [MAC_NUM-1:0]            out_wr_mask,
    output logic [MAC_NUM*BW_ACT-1:0]     out_wr_data,
    output logic                          busy,
`ifdef PERF_CNT_EN
    output logic [31:0]                   perf_cycles,
`endif
    output logic                          done
);

    localparam int unsigned ACCU_NUM  = 1 << ACCU_NUM_LOG2;
    localparam int unsigned DRAIN_CYC = drain_lat(ACCU_NUM_LOG2, RD_LAT);

    state_e r_state, w_state_next;

    // Job configuration latched at start
    logic [DIM_W-1:0] r_ia_h, r_ia_w, r_oa_w, r_k, r_r;
    logic [7:0]       r_shift;

    // Loop indices: i = reduction step, j = row tile, m = output column
    logic [DIM_W-1:0] r_i, r_j, r_m, r_drain;

    logic                      r_out_wr_en;
    logic [DIM_W-1:0]          r_out_wr_row, r_out_wr_col;
    logic [MAC_NUM-1:0]        r_out_wr_mask;
    logic [MAC_NUM*BW_ACT-1:0] r_out_wr_data;

    logic [DIM_W:0]       w_k_full, w_r_full;
    logic                 w_cfg_zero, w_last_i, w_last_drain, w_last_j, w_last_m;
    logic [DIM_W-1:0]     w_row, w_col;
    logic [ACCU_NUM-1:0]  w_lane_valid, w_feed_mask;
    logic [MAC_NUM-1:0]   w_row_valid;
    logic                 w_busy, w_done, w_rd_en, w_clear_acc;
    logic [ACCU_NUM:0]    w_aligned;

    // Ceiling divisions on one extra bit so the rounding add cannot overflow
    assign w_k_full = ({1'b0, cfg_ia_w} + (DIM_W+1)'(ACCU_NUM - 1)) >> ACCU_NUM_LOG2;
    assign w_r_full = ({1'b0, cfg_ia_h} + (DIM_W+1)'(MAC_NUM - 1)) / (DIM_W+1)'(MAC_NUM);

    assign w_cfg_zero   = (cfg_ia_h == '0) || (cfg_ia_w == '0) || (cfg_oa_w == '0);
    assign w_last_i     = (r_i == r_k - DIM_W'(1));
    assign w_last_drain = (r_drain == DIM_W'(DRAIN_CYC - 1));
    assign w_last_j     = (r_j == r_r - DIM_W'(1));
    assign w_last_m     = (r_m == r_oa_w - DIM_W'(1));

    assign w_row = DIM_W'(r_j * MAC_NUM);
    assign w_col = r_i << ACCU_NUM_LOG2;

    // A lane is live while its column is inside the reduction length; only the
    // final step of a ragged ia_w can have dead lanes.
    always_comb begin
        w_lane_valid = '0;
        for (int l = 0; l < int'(ACCU_NUM); l++) begin
            w_lane_valid[l] = ({1'b0, w_col} + (DIM_W+1)'(l)) < {1'b0, r_ia_w};
        end
    end

    always_comb begin
        w_row_valid = '0;
        for (int n = 0; n < int'(MAC_NUM); n++) begin
            w_row_valid[n] = ({1'b0, w_row} + (DIM_W+1)'(n)) < {1'b0, r_ia_h};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = w_cfg_zero ? StDone : StClear;
                end
            end
            StClear: w_state_next = StFeed;
            StFeed: begin
                if (w_last_i) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_last_drain) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: w_state_next = (w_last_j && w_last_m) ? StDone : StClear;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_clear_acc = 1'b1;
        unique case (r_state)
            StClear: w_busy = 1'b1;
            StFeed: begin
                w_busy      = 1'b1;
                w_rd_en     = 1'b1;
                w_clear_acc = 1'b0;
            end
            // Accumulator must hold while in-flight products land and are written
            StDrain, StWrite: begin
                w_busy      = 1'b1;
                w_clear_acc = 1'b0;
            end
            StDone: w_done = 1'b1;
            default: ;
        endcase
        w_feed_mask = w_rd_en ? w_lane_valid : '0;
    end

    // Configuration, loop indices and output-write registers
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_ia_h        <= '0;
            r_ia_w        <= '0;
            r_oa_w        <= '0;
            r_k           <= '0;
            r_r           <= '0;
            r_shift       <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_m           <= '0;
            r_drain       <= '0;
            r_out_wr_en   <= 1'b0;
            r_out_wr_row  <= '0;
            r_out_wr_col  <= '0;
            r_out_wr_mask <= '0;
            r_out_wr_data <= '0;
        end else begin
            r_out_wr_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_ia_h  <= cfg_ia_h;
                        r_ia_w  <= cfg_ia_w;
                        r_oa_w  <= cfg_oa_w;
                        r_k     <= w_k_full[DIM_W-1:0];
                        r_r     <= w_r_full[DIM_W-1:0];
                        r_shift <= cfg_shift;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_m     <= '0;
                        r_drain <= '0;
                    end
                end
                StClear: begin
                    r_i     <= '0;
                    r_drain <= '0;
                end
                StFeed:  r_i     <= r_i + DIM_W'(1);
                StDrain: r_drain <= r_drain + DIM_W'(1);
                StWrite: begin
                    r_out_wr_en   <= 1'b1;
                    r_out_wr_row  <= w_row;
                    r_out_wr_col  <= r_m;
                    r_out_wr_mask <= w_row_valid;
                    r_out_wr_data <= PE_result_out;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_m <= w_last_m ? '0 : r_m + DIM_W'(1);
                    end else begin
                        r_j <= r_j + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // mac_enable and lane mask follow the read strobe by the SRAM latency
    sched_delay_line #(
        .WIDTH (ACCU_NUM + 1),
        .DEPTH (RD_LAT)
    ) u_delay (
        .i_clk  (clk),
        .i_rst  (reset_n),
        .i_data ({w_rd_en, w_feed_mask}),
        .o_data (w_aligned)
    );

`ifdef PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_perf <= '0;
        end else if (r_state == StIdle && start) begin
            r_perf <= '0;
        end else if (w_busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign PE_mac_enable    = w_aligned[ACCU_NUM];
    assign lane_mask        = w_aligned[ACCU_NUM-1:0];
    assign act_rd_en        = w_rd_en;
    assign wet_rd_en        = w_rd_en;
    assign act_rd_row       = w_row;
    assign act_rd_col       = w_col;
    assign wet_rd_row       = w_col;
    assign wet_rd_col       = r_m;
    assign PE_clear_acc     = w_clear_acc;
    assign PE_res_shift_num = r_shift;
    assign out_wr_en        = r_out_wr_en;
    assign out_wr_row       = r_out_wr_row;
    assign out_wr_col       = r_out_wr_col;
    assign out_wr_mask      = r_out_wr_mask;
    assign out_wr_data      = r_out_wr_data;
    assign busy             = w_busy;
    assign done             = w_done;

endmodule

// File: doc/matmul_sched.md
Name: matmul_sched

Overview:
- Sequencing controller for the MultAddTree dot-product datapath; replaces the hand-written loop nest with RTL.
- Walks an OA_H x OA_W output matrix, column-major over m and then rows j, as in OA[j][m] = sum_i IA[j][i] * W[i][m].
- Issues per-cycle read requests to the activation and weight SRAMs, drives PE_mac_enable, PE_clear_acc and PE_res_shift_num, waits out the tree latency, then issues output-SRAM writes.
- Sits between the top-level config/start interface and MultAddTree plus the three on-chip buffers.

Parameters:
- MAC_NUM, 1, parallel output rows (MultAddTree MAC units)
- ACCU_NUM_LOG2, 1, log2 of lanes per MAC; ACCU_NUM = 1<<ACCU_NUM_LOG2
- BW_ACT, 8, bit width of the result word
- DIM_W, 12, bit width of every dimension and index field
- RD_LAT, 1, SRAM read latency in cycles

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-high; the _n suffix is kept for port-name compatibility only
- start  in  1  one-cycle pulse; latches cfg_* and starts a job
- cfg_ia_h  in  DIM_W  rows of IA / OA
- cfg_ia_w  in  DIM_W  reduction length K
- cfg_oa_w  in  DIM_W  columns of W / OA
- cfg_shift  in  8  result right-shift
- act_rd_en  out  1  activation read strobe
- act_rd_row  out  DIM_W  base row j*MAC_NUM
- act_rd_col  out  DIM_W  base column i*ACCU_NUM
- wet_rd_en  out  1  weight read strobe
- wet_rd_row  out  DIM_W  i*ACCU_NUM
- wet_rd_col  out  DIM_W  m
- lane_mask  out  ACCU_NUM  per-lane valid, aligned to SRAM data; the operand mux zeroes masked lanes
- PE_mac_enable  out  1  to MultAddTree
- PE_clear_acc  out  1  high = clear/hold accumulator at zero
- PE_res_shift_num  out  8  to MultAddTree
- PE_result_out  in  MAC_NUM*BW_ACT  from MultAddTree
- out_wr_en  out  1  output write strobe
- out_wr_row  out  DIM_W  j*MAC_NUM
- out_wr_col  out  DIM_W  m
- out_wr_mask  out  MAC_NUM  per-row valid
- out_wr_data  out  MAC_NUM*BW_ACT  registered copy of PE_result_out
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values:
  - All strobes, masks, busy and done = 0.
  - PE_clear_acc = 1.
  - Addresses and out_wr_data = 0.
  - PE_res_shift_num = 0.
  - FSM in IDLE.
- Reset mid-job aborts at the next edge; no further writes are issued.
- Derived counts, latched at start:
  - K = ceil(ia_w/ACCU_NUM)
  - R = ceil(ia_h/MAC_NUM)
  - D = RD_LAT + ACCU_NUM_LOG2 + 2
- FSM IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> (CLEAR | DONE) -> IDLE.
- IDLE:
  - start latches cfg and PE_res_shift_num = cfg_shift.
  - If any of ia_h, ia_w, oa_w is 0, go directly to DONE with no reads or writes.
  - Otherwise go to CLEAR; busy = 1 from the next cycle.
- CLEAR (1 cycle): PE_clear_acc = 1, no reads.
- FEED (K cycles):
  - PE_clear_acc = 0; act_rd_en = wet_rd_en = 1.
  - i counts 0..K-1.
  - On the final i, lanes with index >= ia_w mod ACCU_NUM are masked (when the remainder is nonzero).
- Alignment: PE_mac_enable and lane_mask are rd_en and the lane mask delayed RD_LAT cycles, so they coincide with SRAM data.
- DRAIN: D cycles, no reads.
- WRITE (1 cycle):
  - out_wr_en = 1; out_wr_data = PE_result_out sampled this cycle.
  - out_wr_mask bit n = (j*MAC_NUM+n < ia_h).
  - Then advance j; when j wraps, j = 0 and m++.
  - After the last (R-1, oa_w-1) go to DONE; otherwise go to CLEAR.
- DONE (1 cycle): done = 1, busy drops to 0 in the same cycle.
- Cycles per output tile = 1 + K + D + 1. Job cycles = R*oa_w*(K+D+2) + 1 (DONE).
- start while busy is ignored; cfg_* changes during a job have no effect.
- Index arithmetic is unsigned DIM_W; wrap-around is impossible because the cfg_* limits keep every index below 2^DIM_W.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds output perf_cycles (32 bits), cleared at start.
  - Increments every cycle while busy.
  - Holds its value after done until the next start.
  - Reset value 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package matmul_sched_pkg: FSM state enum (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE) and the drain-latency function of ACCU_NUM_LOG2 and RD_LAT.
- One sub-module, sched_delay_line: a parameterised RD_LAT-deep shift register carrying {mac_enable, lane_mask}.

Test Plan:
- MAC_NUM=1, ACCU_NUM=2, 8x8x8 job with identity W -> 64 writes in (m,j) order; each out_wr_data equals the IA element shifted by cfg_shift; done after 8*8*(4+4+2)+1 = 641 cycles.
- ia_w=5, ACCU_NUM=2 -> 3 FEED cycles; lane_mask = 2'b01 on the third data cycle; result matches the golden model.
- ia_h=3, MAC_NUM=2 -> second row tile has out_wr_mask = 2'b01.
- cfg_oa_w=0 with start -> done one cycle later; no act_rd_en, wet_rd_en or out_wr_en.
- start pulsed again mid-job -> ignored. reset_n=1 asserted mid-DRAIN -> next cycle IDLE, PE_clear_acc=1, no out_wr_en.
- PERF_CNT_EN defined, 100x150x16 job -> perf_cycles = 100*16*(75+4+2) = 129600 when done pulses.
